fetch_queue: RTL
================

# fetch_queue

Parametrised instruction prefetch queue between the I-cache and the IF/ID pipeline register. It replaces single-word, zero-latency fetch with a DEPTH-entry word buffer that:
- keeps up to DEPTH requests in flight to a pipelined I-cache;
- discards stale responses after a redirect;
- (optionally) realigns 16-bit compressed and straddling 32-bit instructions, delivering one aligned instruction per cycle to decode.

## Interface
Parameters:
- DEPTH, 4, queue entries (32-bit words); power of two, ≥2
- ADDR_WIDTH, 32, PC width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- Fq_ReqValid  out  1  fetch request valid
- Fq_ReqAddr  out  ADDR_WIDTH  word-aligned fetch address
- Icache_ReqReady  in  1  I-cache accepts request this cycle
- Icache_RespValid  in  1  in-order response valid
- Icache_RespData  in  32  fetched word
- Fq_InstrValid  out  1  aligned instruction available
- Fq_Instr  out  32  instruction; 16-bit ones zero-extended; 32'h0000_0013 when invalid
- Fq_InstrPC  out  ADDR_WIDTH  PC of Fq_Instr
- Fq_16BitFlag  out  1  Fq_Instr is compressed
- Decode_Ready  in  1  decode consumes Fq_Instr this cycle
- Flush  in  1  redirect (branch/exception)
- Flush_PC  in  ADDR_WIDTH  redirect target

## Operation
State:
- queue[DEPTH] of words, plus head PC
- count and inflight, each $clog2(DEPTH)+1 bits
- drop_cnt, same width
- fetch_pc (word-aligned)
- hoff, head halfword offset (1 bit)

Request path:
- Fq_ReqValid = !Flush && (count + inflight < DEPTH); Fq_ReqAddr = fetch_pc.
- On accept (ReqValid && ReqReady): fetch_pc += 4, inflight += 1.
- Invariant: count + inflight ≤ DEPTH.

Response path:
- Each RespValid decrements inflight.
- If drop_cnt > 0: drop_cnt -= 1, data discarded.
- Otherwise: word written at tail, count += 1.
- RespValid with inflight == 0 is ignored.

Instruction length (RVC only): head halfword h = hoff ? head[31:16] : head[15:0]; 16-bit iff h[1:0] != 2'b11.

Fq_InstrValid:
- 16-bit: count ≥ 1.
- 32-bit with hoff = 0: count ≥ 1.
- 32-bit with hoff = 1: count ≥ 2. Fq_Instr = {next[15:0], head[31:16]}.

Fq_InstrPC = head_pc + 2·hoff.

Consume (Valid && Decode_Ready):
- 16-bit: hoff toggles; pop when hoff was 1.
- 32-bit: pop one word; hoff unchanged.
- Push and pop in the same cycle are permitted.

Flush (priority over consume and push):
- queue emptied (count = 0).
- fetch_pc = {Flush_PC[ADDR_WIDTH-1:2], 2'b00}.
- hoff = Flush_PC[1].
- drop_cnt = inflight − RespValid; a same-cycle response is also discarded.
- No request is issued in the Flush cycle.

Reset (asynchronous):
- fetch_pc = RESET_PC; all counters and hoff = 0.
- Outputs: Fq_ReqValid 0 while rst_n low; Fq_InstrValid 0; Fq_Instr 32'h0000_0013; Fq_InstrPC 0; Fq_16BitFlag 0.
- Reset mid-operation abandons all in-flight state. The I-cache is reset by the same rst_n.

## Timing
- Requests: first request in the first cycle after rst_n deasserts; up to 1 request/cycle while space remains.
- Output: combinational from queue state. A response written at edge N makes the instruction valid in cycle N+1 (one-cycle buffer latency).
- Redirect: Flush in cycle F, first request to the new PC in F+1, first valid instruction the cycle after its response.
- Throughput: 1 instruction/cycle when the queue is non-empty.
- Full (count == DEPTH): ReqValid low.
- Empty: InstrValid low.
- Straddling 32-bit instruction with count == 1: stalls until the next word arrives.

## Configuration
- FQ_RVC_EN defined: compressed support as above. Flush_PC[1] honoured; the realignment mux and hoff are present.
- FQ_RVC_EN undefined:
  - hoff tied to 0; every instruction is the head word; Fq_16BitFlag = 0.
  - Flush_PC[1:0] ignored (redirect to the containing word).
  - Each consume pops one word.

## Test plan
- Reset release, RESET_PC = 32'h8000_0000, 1-cycle I-cache, Decode_Ready = 1 → ReqAddr 8000_0000, 8000_0004, …; Fq_InstrPC follows the same sequence, one instruction/cycle after the first response.
- Decode_Ready = 0, DEPTH = 4, I-cache always ready → exactly 4 requests, then ReqValid low. One consume → exactly one new request.
- Two responses in flight, Flush with Flush_PC = 0x100 → both stale words dropped; next Fq_InstrPC = 0x100 with the word fetched from 0x100.
- FQ_RVC_EN, words 0x0513_0001 @0x0 and 0x0001_0050 @0x4 → (PC 0x0, 0x0000_0001, 16b = 1), (PC 0x2, 0x0050_0513, 16b = 0), (PC 0x6, 0x0000_0001, 16b = 1).
- FQ_RVC_EN, Flush_PC = 0x102, word @0x100 = 0x0001_4501 → first output PC 0x102, Fq_Instr 0x0000_0001.
- FQ_RVC_EN undefined, Flush with Flush_PC = 0x102 in the same cycle as RespValid → that response dropped; first request address 0x100; first Fq_InstrPC 0x100.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch queue's I-cache request/response,
// decode delivery and redirect signals.
// master = fetch queue side, slave = I-cache/decode/redirect side.
interface fetch_queue_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  Fq_ReqValid;
   logic [ADDR_WIDTH-1:0] Fq_ReqAddr;
   logic                  Icache_ReqReady;
   logic                  Icache_RespValid;
   logic [31:0]           Icache_RespData;
   logic                  Fq_InstrValid;
   logic [31:0]           Fq_Instr;
   logic [ADDR_WIDTH-1:0] Fq_InstrPC;
   logic                  Fq_16BitFlag;
   logic                  Decode_Ready;
   logic                  Flush;
   logic [ADDR_WIDTH-1:0] Flush_PC;

   modport master (
      output Fq_ReqValid, Fq_ReqAddr, Fq_InstrValid, Fq_Instr, Fq_InstrPC, Fq_16BitFlag,
      input  Icache_ReqReady, Icache_RespValid, Icache_RespData, Decode_Ready, Flush, Flush_PC
   );

   modport slave (
      input  Fq_ReqValid, Fq_ReqAddr, Fq_InstrValid, Fq_Instr, Fq_InstrPC, Fq_16BitFlag,
      output Icache_ReqReady, Icache_RespValid, Icache_RespData, Decode_Ready, Flush, Flush_PC
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-word instruction prefetch buffer between a pipelined,
// in-order I-cache and decode. Tracks requests in flight, discards responses
// that were requested before a redirect, and hands decode one instruction
// per cycle.
// Optional macro FQ_RVC_EN: halfword realignment for 16-bit compressed and
// word-straddling 32-bit instructions. Without it every instruction is the
// head word and redirects go to the containing word.
module fetch_queue #(
   parameter int unsigned          DEPTH      = 4,
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input logic           clk,
   input logic           rst_n,
   fetch_queue_if.master bus
);
   localparam int unsigned           PW      = $clog2(DEPTH);
   localparam int unsigned           CW      = PW + 1;
   localparam logic [31:0]           NOP     = 32'h0000_0013;
   localparam logic [CW:0]           DEPTH_W = DEPTH;
   localparam logic [ADDR_WIDTH-1:0] WORD    = 4;

   logic [DEPTH-1:0][31:0] queue_q;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
   logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
   logic [ADDR_WIDTH-1:0]  flush_word;
   logic                   hoff_q;

   logic [CW:0]  occ;
   logic         req_vld, req_fire, resp, push, pop, consume;
   logic         vld, is16;
   logic [31:0]  head_w, instr_raw;

   assign flush_word = {bus.Flush_PC[ADDR_WIDTH-1:2], 2'b00};
   assign head_w     = queue_q[rd_ptr_q];

   // Request side: one outstanding slot per free queue entry
   assign occ      = {1'b0, count_q} + {1'b0, inflight_q};
   assign req_vld  = rst_n && !bus.Flush && (occ < DEPTH_W);
   assign req_fire = req_vld && bus.Icache_ReqReady;

   // Responses with nothing in flight are spurious; flush-cycle and stale
   // responses are consumed from inflight but never written
   assign resp = bus.Icache_RespValid && (inflight_q != '0);
   assign push = resp && (drop_q == '0) && !bus.Flush;

`ifdef FQ_RVC_EN
   logic        hoff_d;
   logic [15:0] half;
   logic [31:0] next_w;

   assign next_w = queue_q[rd_ptr_q + PW'(1)];
   assign half   = hoff_q ? head_w[31:16] : head_w[15:0];
   assign is16   = (half[1:0] != 2'b11);

   // Realignment: a straddling 32-bit instruction needs the following word too
   always_comb begin
      vld       = (count_q != '0);
      instr_raw = head_w;
      if (is16) begin
         instr_raw = {16'h0000, half};
      end else if (hoff_q) begin
         vld       = (count_q >= CW'(2));
         instr_raw = {next_w[15:0], head_w[31:16]};
      end
   end

   assign consume = vld && bus.Decode_Ready;
   // A compressed instruction in the upper half finishes the word
   assign pop     = consume && (!is16 || hoff_q);

   // Halfword offset of the head instruction
   always_comb begin
      hoff_d = hoff_q;
      if (bus.Flush)            hoff_d = bus.Flush_PC[1];
      else if (consume && is16) hoff_d = ~hoff_q;
   end

   // Halfword offset register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hoff_q <= 1'b0;
      else        hoff_q <= hoff_d;
   end
`else
   logic unused_flush_lo;

   assign unused_flush_lo = ^bus.Flush_PC[1:0];
   assign hoff_q          = 1'b0;
   assign is16            = 1'b0;
   assign vld             = (count_q != '0);
   assign instr_raw       = head_w;
   assign consume         = vld && bus.Decode_Ready;
   assign pop             = consume;
`endif

   assign bus.Fq_ReqValid   = req_vld;
   assign bus.Fq_ReqAddr    = fetch_pc_q;
   assign bus.Fq_InstrValid = vld;
   assign bus.Fq_Instr      = vld ? instr_raw : NOP;
   assign bus.Fq_16BitFlag  = vld && is16;
   assign bus.Fq_InstrPC    = rst_n ? (head_pc_q + {{(ADDR_WIDTH-2){1'b0}}, hoff_q, 1'b0}) : '0;

   // Next-state for counters, pointers and PCs; redirect overrides everything
   always_comb begin
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp);
      drop_d     = (resp && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      fetch_pc_d = req_fire ? fetch_pc_q + WORD : fetch_pc_q;
      head_pc_d  = pop ? head_pc_q + WORD : head_pc_q;
      if (bus.Flush) begin
         count_d    = '0;
         inflight_d = inflight_q - CW'(resp);
         drop_d     = inflight_q - CW'(resp);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = flush_word;
         head_pc_d  = flush_word;
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fetch_pc_q <= RESET_PC;
         head_pc_q  <= RESET_PC;
      end else begin
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fetch_pc_q <= fetch_pc_d;
         head_pc_q  <= head_pc_d;
      end
   end

   // Word storage; contents only matter once counted, so no reset
   always_ff @(posedge clk) begin
      if (push) queue_q[wr_ptr_q] <= bus.Icache_RespData;
   end
endmodule
